// File: rtl/mem_if_defs.sv
// Shared definitions for the data-memory initiator: FSM encodings, bus defaults, alignment mask.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_if_defs;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    // Access FSM encodings; values are fixed because external debug tooling decodes them.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // The wait counter covers WAIT_CYCLES in 0..15.
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] wait_cnt_t;

    // A request is misaligned when any byte-offset bit is set.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter that times how long an access is held on the memory bus.
// Latency: load and decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; en stalls the count, load overrides en.
module mem_wait_counter
    import mem_if_defs::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      en,
    input  wait_cnt_t load_val,
    output logic      zero
);

    wait_cnt_t cnt;

    // Load on accept, otherwise count down while enabled and not yet exhausted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_master.sv
// Data-memory initiator: runs one load/store at a time, holding the bus for WAIT_CYCLES+1 cycles.
// Latency: resp_valid WAIT_CYCLES+2 cycles after accept (1 cycle for a misaligned request).
// Backpressure: req_ready only in IDLE; stall freezes the MEM stage while a request waits or is in ACCESS.
module mem_access_master
    import mem_if_defs::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam wait_cnt_t WAIT_LOAD = wait_cnt_t'(WAIT_CYCLES);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       write_q;
    logic       err_q;
    logic       cnt_zero;
    logic       in_idle;
    logic       in_access;
    logic       in_done;
    logic       accept;
    logic       misaligned;

    assign in_idle    = (state == ST_IDLE);
    assign in_access  = (state == ST_ACCESS);
    assign in_done    = (state == ST_DONE);
    assign accept     = in_idle && req_valid;
    assign misaligned = is_misaligned(req_addr[1:0]);

    mem_wait_counter u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .en       (in_access),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero)
    );

    // Next-state: misaligned requests skip the bus and report immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid) state_nxt = misaligned ? ST_DONE : ST_ACCESS;
            ST_ACCESS: if (cnt_zero)  state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset is asynchronous so the decoded strobes drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the request at accept; later req_* activity is ignored until IDLE again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            write_q   <= req_write;
            err_q     <= misaligned;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
        end
    end

    // Sample load data at the end of the last ACCESS cycle; stores and errors leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= '0;
        end else if (in_access && !write_q && cnt_zero) begin
            resp_rdata <= mem_rdata;
        end
    end

    // Moore outputs: write strobe only in the final ACCESS cycle gives exactly one write edge.
    assign mem_read   = in_access && !write_q;
    assign mem_write  = in_access && write_q && cnt_zero;
    assign req_ready  = in_idle;
    assign resp_valid = in_done;
    assign resp_err   = in_done && err_q;
    assign stall      = accept || in_access;

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench: directed plus random load/store traffic against a word-array reference.
// Latency: expected response cycle is computed per request from WAIT_CYCLES.
// Backpressure: driver holds req_valid until req_ready is seen, with a bounded wait.
module tb_mem_access_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int WC = 3;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            cyc;
        int            nrd;
        int            nwr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          stall;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    wire  [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_master #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall      (stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Data memory: 64 words, wraps on address bits [7:2], writes on rising edge.
    logic [DW-1:0] dmem     [64];
    logic [DW-1:0] init_val [64];
    logic          mem_init = 1'b1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) dmem[i] <= init_val[i];
        end else if (mem_write) begin
            dmem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_read ? dmem[mem_addr[7:2]] : {DW{1'bz}};

    // Reference model state.
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] ref_rdata;
    exp_t          sb [$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int wr_total = 0;
    int exp_writes = 0;
    bit mon_en = 1'b0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle protocol checks and scoreboard pop on each response.
    always @(negedge clk) begin
        if (rst) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else if (mon_en) begin
            check("rw_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
            check("req_ready", {63'd0, req_ready}, {63'd0, sb.size() == 0});
            check("stall", {63'd0, stall},
                  {63'd0, (req_valid && sb.size() == 0) || (sb.size() > 0 && !resp_valid)});
            if (mem_read)  rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                wr_total++;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_err", {63'd0, resp_err}, {63'd0, mon_e.err});
                    check("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
                    check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("read_cycles", 64'(rd_cnt), 64'(mon_e.nrd));
                    check("write_edges", 64'(wr_cnt), 64'(mon_e.nwr));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Issue one request, wait for acceptance, push the expected response.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input bit hold, output int acc_cyc);
        int   waited = 0;
        exp_t e;
        logic [5:0] idx;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        acc_cyc   = -1;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 64'd0, 64'd1);
                req_valid = 1'b0;
                return;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        idx   = addr[7:2];
        e.err = (addr[1:0] != 2'b00);
        if (!e.err) begin
            if (wr) ref_mem[idx] = wd;
            else    ref_rdata = ref_mem[idx];
        end
        e.rdata = ref_rdata;
        e.cyc   = acc_cyc + (e.err ? 1 : WC + 2);
        e.nrd   = (!e.err && !wr) ? WC + 1 : 0;
        e.nwr   = (!e.err && wr) ? 1 : 0;
        exp_writes += e.nwr;
        sb.push_back(e);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a;
        int a_prev;
        logic [AW-1:0] ra;
        logic          rw;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            init_val[i] = $urandom;
            ref_mem[i]  = init_val[i];
        end
        ref_rdata = '0;
        @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_err", {63'd0, resp_err}, 64'd0);
        check("rst_mem_read", {63'd0, mem_read}, 64'd0);
        check("rst_mem_write", {63'd0, mem_write}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Store then load the same word.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, a);
        drain();
        check("mem_word4", 64'(dmem[4]), 64'hDEADBEEF);
        issue(1'b0, 32'h10, '0, 1'b0, a);
        drain();
        // Misaligned load: error, data held.
        issue(1'b0, 32'h13, '0, 1'b0, a);
        drain();
        // Address wrap onto word 1.
        issue(1'b1, 32'h104, 32'h5, 1'b0, a);
        drain();
        check("mem_word1", 64'(dmem[1]), 64'h5);
        issue(1'b0, 32'h4, '0, 1'b0, a);
        drain();

        // Reset in the second ACCESS cycle of a load.
        issue(1'b0, 32'h10, '0, 1'b0, a);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_mem_read", {63'd0, mem_read}, 64'd0);
        check("abort_mem_write", {63'd0, mem_write}, 64'd0);
        check("abort_stall", {63'd0, stall}, 64'd0);
        check("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
        sb.delete();
        ref_rdata = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_req_ready", {63'd0, req_ready}, 64'd1);
        check("abort_resp_rdata", 64'(resp_rdata), 64'd0);
        @(posedge clk);
        #1;
        issue(1'b0, 32'h10, '0, 1'b0, a);
        drain();

        // Three stores with req_valid held high throughout.
        issue(1'b1, 32'h20, 32'h11111111, 1'b1, a_prev);
        issue(1'b1, 32'h24, 32'h22222222, 1'b1, a);
        check("issue_interval_1", 64'(a - a_prev), 64'(WC + 3));
        a_prev = a;
        issue(1'b1, 32'h28, 32'h33333333, 1'b0, a);
        check("issue_interval_2", 64'(a - a_prev), 64'(WC + 3));
        drain();

        // Random traffic with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            issue(rw, ra, $urandom, 1'b0, a);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("total_write_edges", 64'(wr_total), 64'(exp_writes));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
